// File: rtl/ps2_rx_fifo_if.sv
// rtl/ps2_rx_fifo_if.sv - read-side interface of the PS/2 key event FIFO
interface ps2_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          rd_en;
  logic [7:0]    rd_code;
  logic          rd_extended;
  logic          rd_released;
  logic          empty;
  logic [CW-1:0] count;

  // consumer side: pops entries, observes the head
  modport master (
    output rd_en,
    input  rd_code, rd_extended, rd_released, empty, count
  );

  // FIFO side: presents the head, accepts pops
  modport slave (
    input  rd_en,
    output rd_code, rd_extended, rd_released, empty, count
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver with prefix folding and FWFT event FIFO
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  ps2_rx_fifo_if.slave rd,
  output logic         parity_err,
  output logic         frame_err,
  output logic         overflow
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    CODE_EXT = 8'hE0;
  localparam logic [7:0]    CODE_REL = 8'hF0;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   ext_q, ext_d;
  logic                   rel_q, rel_d;
  logic [9:0]             mem_q [FIFO_DEPTH];
  logic [9:0]             mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;

  logic clk_s, sample, fall, timeout, stop_edge, byte_ok, push, pop, full, wr;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign sample = data_sync_q[SYNC_STAGES-1];
  assign fall   = !clk_s && clk_prev_q;
  assign full   = (count_q == FULL_CNT);
  assign pop    = rd.rd_en && (count_q != '0);

  assign rd.rd_code     = mem_q[rd_ptr_q][7:0];
  assign rd.rd_released = mem_q[rd_ptr_q][8];
  assign rd.rd_extended = mem_q[rd_ptr_q][9];
  assign rd.empty       = (count_q == '0);
  assign rd.count       = count_q;

  // state register: every flop, asynchronously cleared; pins idle high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

  // synchroniser chains and previous-clock register for falling-edge detect
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d  = clk_s;
  end

  // next-state logic of the deframer; a timeout aborts any in-frame state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall && !sample) state_d = DATA;
      DATA:    if (timeout) state_d = IDLE;
               else if (fall && bit_cnt_q == 3'd7) state_d = PARITY;
      PARITY:  if (timeout) state_d = IDLE;
               else if (fall) state_d = STOP;
      STOP:    if (timeout || fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // frame evaluation and error pulses; a bad stop bit masks a parity failure
  always_comb begin
    timeout    = (state_q != IDLE) && !fall && (tmo_q == TMO_LAST);
    stop_edge  = fall && (state_q == STOP);
    frame_err  = timeout || (stop_edge && !sample);
    parity_err = stop_edge && sample && !(^{shift_q, parity_q});
    byte_ok    = stop_edge && sample && (^{shift_q, parity_q});
    push       = byte_ok && (shift_q != CODE_EXT) && (shift_q != CODE_REL);
    overflow   = push && full && !pop;
    wr         = push && (!full || pop);
  end

  // bit capture, inter-edge timeout counter and prefix flag folding
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    ext_d     = ext_q;
    rel_d     = rel_q;
    tmo_d     = (state_q == IDLE || fall || timeout) ? '0 : tmo_q + TW'(1);
    if (fall) begin
      case (state_q)
        IDLE:    bit_cnt_d = 3'd0;
        DATA: begin
          shift_d[bit_cnt_q] = sample;
          bit_cnt_d          = bit_cnt_q + 3'd1;
        end
        PARITY:  parity_d = sample;
        default: ;
      endcase
    end
    if (frame_err || parity_err) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (byte_ok) begin
      if (shift_q == CODE_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == CODE_REL) begin
        rel_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
  end

  // FWFT FIFO: write at tail, advance head on pop, exact occupancy count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr) begin
      mem_d[wr_ptr_q] = {ext_q, rel_q, shift_q};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8;
  localparam int TMO   = 300;
  localparam int H     = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic parity_err, frame_err, overflow;

  ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) rd_if ();

  ps2_rx_fifo #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(TMO),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .rd(rd_if.slave),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       bad_stop;
    int         exp_perr;
    int         exp_ferr;
    logic       exp_push;
    logic       exp_ext;
    logic       exp_rel;
  } vec_t;

  vec_t       tbl [13];
  logic [9:0] sb [$];
  int n_checks = 0;
  int n_err = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int n_ovf = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (parity_err) n_perr++;
      if (frame_err)  n_ferr++;
      if (overflow)   n_ovf++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_expect(input string name);
    logic [9:0] e;
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: got entry with scoreboard empty expected none", name);
    end else begin
      e = sb.pop_front();
      check(name, {21'd0, rd_if.empty, rd_if.rd_extended, rd_if.rd_released, rd_if.rd_code},
            {21'd0, 1'b0, e});
    end
  endtask

  task automatic read_check(input string name);
    pop_expect(name);
    rd_if.rd_en = 1'b1;
    tick(1);
    rd_if.rd_en = 1'b0;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(H);
    ps2_clk = 1'b0;
    tick(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop,
                            input logic pop_at_stop);
    logic par;
    par = ~(^code) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(par);
    ps2_data = ~bad_stop;
    tick(H);
    ps2_clk = 1'b0;
    if (pop_at_stop) begin
      tick(2);
      pop_expect("head_at_stop_pop");
      rd_if.rd_en = 1'b1;
      tick(1);
      rd_if.rd_en = 1'b0;
      tick(H - 3);
    end else begin
      tick(H);
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(6);
  endtask

  initial begin
    int p0, f0, o0, first;
    tbl[0]  = '{8'h1C, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'h75, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{8'h1C, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'hF0, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{8'h1C, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{8'h6B, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{8'h6B, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{8'hF0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{8'hE0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{8'h74, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1};

    rd_if.rd_en = 1'b0;
    tick(3);
    check("reset_empty", 32'(rd_if.empty), 32'd1);
    check("reset_count", 32'(rd_if.count), 32'd0);
    check("reset_head", {21'd0, rd_if.rd_extended, rd_if.rd_released, rd_if.rd_code}, 32'd0);
    check("reset_pulses", {29'd0, parity_err, frame_err, overflow}, 32'd0);
    reset_n = 1'b1;
    tick(3);

    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    sb.push_back({2'b00, 8'h1C});
    check("single_count", 32'(rd_if.count), 32'd1);
    read_check("single_entry");
    check("single_empty_after_read", 32'(rd_if.empty), 32'd1);
    check("single_count_after_read", 32'(rd_if.count), 32'd0);

    for (int i = 0; i < 13; i++) begin
      p0 = n_perr;
      f0 = n_ferr;
      send_frame(tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop, 1'b0);
      if (tbl[i].exp_push) sb.push_back({tbl[i].exp_ext, tbl[i].exp_rel, tbl[i].code});
      check($sformatf("vec%0d_parity_err", i), 32'(n_perr - p0), 32'(tbl[i].exp_perr));
      check($sformatf("vec%0d_frame_err", i), 32'(n_ferr - f0), 32'(tbl[i].exp_ferr));
      check($sformatf("vec%0d_count", i), 32'(rd_if.count), 32'(sb.size()));
    end
    while (sb.size() > 0) read_check("table_drain");
    check("table_drain_empty", 32'(rd_if.empty), 32'd1);

    f0 = n_ferr;
    first = 0;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    tick(H);
    ps2_clk = 1'b0;
    for (int n = 1; n <= TMO + 20; n++) begin
      @(negedge clk);
      if (n == H) ps2_clk = 1'b1;
      if (frame_err && first == 0) first = n;
    end
    check("timeout_pulse_cycle", 32'(first), 32'(TMO + 3));
    check("timeout_pulse_count", 32'(n_ferr - f0), 32'd1);
    tick(4);
    p0 = n_perr;
    f0 = n_ferr;
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    sb.push_back({2'b00, 8'h29});
    check("after_timeout_errs", 32'((n_perr - p0) + (n_ferr - f0)), 32'd0);
    read_check("after_timeout_entry");

    o0 = n_ovf;
    for (int c = 1; c <= 9; c++) begin
      send_frame(8'(c), 1'b0, 1'b0, 1'b0);
      if (sb.size() < DEPTH) sb.push_back({2'b00, 8'(c)});
      if (c == 8) check("ovf_none_at_8", 32'(n_ovf - o0), 32'd0);
    end
    check("ovf_pulse_on_9th", 32'(n_ovf - o0), 32'd1);
    check("ovf_count_full", 32'(rd_if.count), 32'(DEPTH));
    send_frame(8'h0A, 1'b0, 1'b0, 1'b1);
    sb.push_back({2'b00, 8'h0A});
    check("full_push_pop_no_ovf", 32'(n_ovf - o0), 32'd1);
    check("full_push_pop_count", 32'(rd_if.count), 32'(DEPTH));
    while (sb.size() > 0) read_check("ovf_drain");
    check("ovf_drain_count", 32'(rd_if.count), 32'd0);

    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    sb.push_back({2'b00, 8'h33});
    send_frame(8'h44, 1'b0, 1'b0, 1'b1);
    sb.push_back({2'b00, 8'h44});
    check("one_push_pop_count", 32'(rd_if.count), 32'd1);
    read_check("one_push_pop_head");

    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    sb.push_back({2'b00, 8'h11});
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_empty", 32'(rd_if.empty), 32'd1);
    check("async_reset_count", 32'(rd_if.count), 32'd0);
    check("async_reset_head", {21'd0, rd_if.rd_extended, rd_if.rd_released, rd_if.rd_code}, 32'd0);
    check("async_reset_pulses", {29'd0, parity_err, frame_err, overflow}, 32'd0);
    sb.delete();
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(3);
    p0 = n_perr;
    f0 = n_ferr;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    sb.push_back({2'b00, 8'h5A});
    check("post_reset_errs", 32'((n_perr - p0) + (n_ferr - f0)), 32'd0);
    check("post_reset_count", 32'(rd_if.count), 32'd1);
    read_check("post_reset_entry");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
